// File: rtl/alu_pipe_stage.sv
// nqcpu execute stage: operand select, single-cycle ALU or iterative multiply, registered output.
// Define ALU_FWD_EN to let a later stage's result replace stale register reads.
module alu_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [1:0]        in_src1_sel,
  input  logic [1:0]        in_src2_sel,
  input  logic [REG_AW-1:0] in_rega,
  input  logic [REG_AW-1:0] in_regb,
  input  logic [DATA_W-1:0] in_dataa,
  input  logic [DATA_W-1:0] in_datab,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_reg,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_PX  = 4'd8;
  localparam logic [3:0] OP_PY  = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, stateNext;

  logic              accept, isMul;
  logic [DATA_W-1:0] regA, regB, opX, opY, aluRes;
  logic              aluCarry;
  logic [DATA_W:0]   sum;

  logic [2*DATA_W-1:0] mcandReg, accReg;
  logic [DATA_W-1:0]   mplierReg, immShadow, pcShadow;
  logic [CTRL_W-1:0]   ctrlShadow;
  logic [CNT_W-1:0]    cntReg;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign isMul    = (in_op == OP_MUL);
  assign busy     = (state == MUL);

`ifdef ALU_FWD_EN
  assign regA = (fwd_valid && fwd_reg == in_rega) ? fwd_data : in_dataa;
  assign regB = (fwd_valid && fwd_reg == in_regb) ? fwd_data : in_datab;
`else
  logic unusedFwd;
  assign unusedFwd = ^{fwd_valid, fwd_reg, fwd_data, in_rega, in_regb};
  assign regA = in_dataa;
  assign regB = in_datab;
`endif

  always_comb begin
    opX = regA;
    case (in_src1_sel)
      2'd0:    opX = regA;
      2'd1:    opX = in_mem_data;
      2'd2:    opX = in_imm;
      default: opX = in_pc;
    endcase
    opY = regB;
    case (in_src2_sel)
      2'd0:    opY = regB;
      2'd1:    opY = ~regB;
      2'd2:    opY = in_pc;
      default: opY = in_imm;
    endcase
  end

  // Undefined opcodes (and MUL, which completes elsewhere) fall through to zero.
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    sum      = '0;
    case (in_op)
      OP_ADD: begin
        sum      = {1'b0, opX} + {1'b0, opY};
        aluRes   = sum[DATA_W-1:0];
        aluCarry = sum[DATA_W];
      end
      OP_SUB: begin
        sum      = {1'b0, opX} + {1'b0, ~opY} + (DATA_W+1)'(1);
        aluRes   = sum[DATA_W-1:0];
        aluCarry = sum[DATA_W];
      end
      OP_AND: aluRes = opX & opY;
      OP_OR:  aluRes = opX | opY;
      OP_XOR: aluRes = opX ^ opY;
      OP_NOT: aluRes = ~opX;
      OP_SHL: begin
        aluRes   = {opX[DATA_W-2:0], 1'b0};
        aluCarry = opX[DATA_W-1];
      end
      OP_SHR: begin
        aluRes   = {1'b0, opX[DATA_W-1:1]};
        aluCarry = opX[0];
      end
      OP_PX:  aluRes = opX;
      OP_PY:  aluRes = opY;
      default: ;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && isMul) stateNext = MUL;
      MUL:     if (cntReg == CNT_W'(DATA_W - 1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Shift-add multiply: one multiplier bit per cycle, DONE publishes the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcandReg   <= '0;
      mplierReg  <= '0;
      accReg     <= '0;
      cntReg     <= '0;
      ctrlShadow <= '0;
      immShadow  <= '0;
      pcShadow   <= '0;
    end else if (accept && isMul) begin
      mcandReg   <= {{DATA_W{1'b0}}, opX};
      mplierReg  <= opY;
      accReg     <= '0;
      cntReg     <= '0;
      ctrlShadow <= in_ctrl;
      immShadow  <= in_imm;
      pcShadow   <= in_pc;
    end else if (state == MUL) begin
      if (mplierReg[0]) accReg <= accReg + mcandReg;
      mcandReg  <= mcandReg << 1;
      mplierReg <= mplierReg >> 1;
      cntReg    <= cntReg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_ctrl   <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
    end else if (accept && !isMul) begin
      out_valid  <= 1'b1;
      out_result <= aluRes;
      out_zero   <= (aluRes == '0);
      out_carry  <= aluCarry;
      out_ctrl   <= in_ctrl;
      out_imm    <= in_imm;
      out_pc     <= in_pc;
    end else if (state == DONE) begin
      out_valid  <= 1'b1;
      out_result <= accReg[DATA_W-1:0];
      out_zero   <= (accReg[DATA_W-1:0] == '0);
      out_carry  <= |accReg[2*DATA_W-1:DATA_W];
      out_ctrl   <= ctrlShadow;
      out_imm    <= immShadow;
      out_pc     <= pcShadow;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
